cache_miss_ctrl: RTL and testbench
==================================

# cache_miss_ctrl

Memory-stage miss/refill controller for the 2-way set-associative data cache. It sits between the cache and the word-addressed data memory. On a load miss it stalls the pipeline, fetches the word over a req/ack handshake and pulses a fill into the cache. All stores are written through to memory under stall, and saturating access/miss counters are kept for performance measurement.

## Interface
Parameters:
- CNT_W, 16, width of performance counters
- NUM_SET, 4, cache sets (passed through to package constants; no logic depends on it here)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- MemReadM  in  1  load in M stage
- MemWriteM  in  1  store in M stage
- AddrM  in  32  byte address (ALUResultM)
- WriteDataM  in  32  store data
- CacheHit  in  1  hit from cache lookup (combinational)
- CacheData  in  32  cache read data
- StallM  out  1  freeze F/D/E/M pipeline registers
- ReadDataM  out  32  load result toward ReadDataW
- FillEn  out  1  one-cycle cache write strobe
- FillAddr  out  32  word-aligned fill address
- FillData  out  32  fill word
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  {AddrM[31:2],2'b00}, registered
- mem_wdata  out  32  registered store data
- mem_ack  in  1  one-cycle completion from memory
- mem_rdata  in  32  read data, valid with mem_ack
- AccessCount  out  CNT_W  completed memory instructions
- MissCount  out  CNT_W  load misses

## Operation
- States: IDLE, RD_WAIT, WR_WAIT, FILL, DONE.
- IDLE:
  - MemWriteM=1 (takes priority over MemReadM) -> latch address and data, go to WR_WAIT.
  - Else MemReadM=1 and CacheHit=0 -> latch address, go to RD_WAIT, MissCount++.
  - Else stay in IDLE.
- RD_WAIT: mem_req=1, mem_we=0. On mem_ack, capture mem_rdata into fill_buf and go to FILL.
- WR_WAIT: mem_req=1, mem_we=1. On mem_ack, go to DONE.
- FILL: FillEn=1, FillAddr=latched address, FillData=fill_buf, ReadDataM=fill_buf. Next state IDLE.
- DONE: next state IDLE. Exists so the store advances exactly once and is not reissued.
- StallM = (IDLE and (MemWriteM or (MemReadM and !CacheHit))) or RD_WAIT or WR_WAIT. StallM is combinational and low in FILL and DONE.
- ReadDataM = fill_buf in FILL, otherwise CacheData.
- mem_addr and mem_wdata are stable for the whole time mem_req is high. mem_ack while mem_req=0 is ignored.
- AccessCount++ in any cycle with (MemReadM or MemWriteM) and StallM=0.
- Both counters saturate at all-ones and do not wrap.
- The cache performs its own store update. This block does not drive a fill for stores.

## Timing
- Load hit: 0 added cycles, StallM stays 0.
- Load miss, with detect in cycle 0:
  - mem_req rises in cycle 1.
  - mem_ack arrives earliest in cycle 1, or at any cycle k ≥ 1.
  - FILL occurs in cycle k+1; the instruction leaves M at the end of that cycle.
  - Total penalty is k+1 stall cycles.
- Store: same shape as a load miss, with DONE in place of FILL.
- mem_req drops in the cycle after mem_ack. There are no back-to-back requests without passing through IDLE.
- Reset values:
  - State IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - FillEn=0, fill_buf=0, both counters 0.
  - StallM and ReadDataM follow the combinational rules.
- rst during RD_WAIT or WR_WAIT abandons the transaction. Memory must tolerate a dropped request, and an ack arriving after reset is ignored.
- AddrM[1:0] is ignored (word access only).

## Structure
- Shared package cache_pkg holds:
  - typedef enum logic [2:0] miss_state_t {IDLE, RD_WAIT, WR_WAIT, FILL, DONE}
  - localparam NUM_SET, TAG_W=28, SET_W=2, OFF_W=2
- Sub-module sat_counter #(W) (inc, count), instantiated twice.
- Everything else is flat: one state register, one always_ff for registers, one always_comb for next-state and output logic.

## Test plan
- Load hit: MemReadM=1, CacheHit=1, CacheData=0xDEADBEEF -> StallM=0, ReadDataM=0xDEADBEEF, no mem_req, AccessCount=1.
- Load miss with ack latency 3: AddrM=0x00000107 -> mem_addr=0x00000104, StallM high for 4 cycles, FILL cycle has FillEn=1, FillData=ReadDataM=mem_rdata=0x12345678, MissCount=1.
- Store: MemWriteM=1, AddrM=0x20, WriteDataM=0xA5A5A5A5 -> mem_we=1, mem_wdata=0xA5A5A5A5, one DONE cycle, exactly one mem_req burst, FillEn never set.
- Read and write asserted together -> write path taken, MissCount unchanged.
- rst asserted mid RD_WAIT, then a late mem_ack -> state IDLE, mem_req=0, counters 0, no FillEn.
- Counter saturation with CNT_W=2: 5 load misses -> MissCount=3.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and geometry constants for the 2-way set-associative data cache
// and its miss/refill controller.
package cache_pkg;

  localparam int NUM_SET = 4;
  localparam int TAG_W   = 28;
  localparam int SET_W   = 2;
  localparam int OFF_W   = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    WR_WAIT = 3'd2,
    FILL    = 3'd3,
    DONE    = 3'd4
  } miss_state_t;

  // Memory is word addressed; the byte offset is dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:OFF_W], {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for performance measurement; holds at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: increment only below the saturation value.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_miss_ctrl.sv
// Memory-stage miss/refill controller: stalls on load misses and stores,
// runs the memory req/ack handshake, and pulses a one-cycle cache fill.
module cache_miss_ctrl
  import cache_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int NUM_SET = cache_pkg::NUM_SET
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemReadM,
  input  logic             MemWriteM,
  input  logic [31:0]      AddrM,
  input  logic [31:0]      WriteDataM,
  input  logic             CacheHit,
  input  logic [31:0]      CacheData,
  output logic             StallM,
  output logic [31:0]      ReadDataM,
  output logic             FillEn,
  output logic [31:0]      FillAddr,
  output logic [31:0]      FillData,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] AccessCount,
  output logic [CNT_W-1:0] MissCount
);

  miss_state_t state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] fill_buf_q, fill_buf_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic        fill_en_q, fill_en_d;
  logic        stall_s;
  logic [31:0] read_data_s;
  logic        miss_inc_s;
  logic        access_inc_s;
  logic        unused_ok;

  // Next-state, capture and output decode.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    fill_buf_d  = fill_buf_q;
    stall_s     = 1'b0;
    read_data_s = CacheData;
    miss_inc_s  = 1'b0;

    case (state_q)
      IDLE: begin
        // A store wins over a load when both are flagged in M.
        if (MemWriteM) begin
          state_d = WR_WAIT;
          addr_d  = word_align(AddrM);
          wdata_d = WriteDataM;
          stall_s = 1'b1;
        end else if (MemReadM && !CacheHit) begin
          state_d    = RD_WAIT;
          addr_d     = word_align(AddrM);
          stall_s    = 1'b1;
          miss_inc_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        stall_s = 1'b1;
        if (mem_ack && mem_req_q) begin
          fill_buf_d = mem_rdata;
          state_d    = FILL;
        end else begin
          state_d = RD_WAIT;
        end
      end
      WR_WAIT: begin
        stall_s = 1'b1;
        if (mem_ack && mem_req_q) begin
          state_d = DONE;
        end else begin
          state_d = WR_WAIT;
        end
      end
      FILL: begin
        read_data_s = fill_buf_q;
        state_d     = IDLE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Request/strobe flops follow the state being entered, so they line up
    // with the registered state in the following cycle.
    mem_req_d    = (state_d == RD_WAIT) || (state_d == WR_WAIT);
    mem_we_d     = (state_d == WR_WAIT);
    fill_en_d    = (state_d == FILL);
    access_inc_s = (MemReadM || MemWriteM) && !stall_s;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      fill_buf_q <= 32'h0000_0000;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      fill_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      fill_buf_q <= fill_buf_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      fill_en_q  <= fill_en_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_access_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (access_inc_s),
    .count (AccessCount)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc_s),
    .count (MissCount)
  );

  assign StallM    = stall_s;
  assign ReadDataM = read_data_s;
  assign FillEn    = fill_en_q;
  assign FillAddr  = addr_q;
  assign FillData  = fill_buf_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Byte offset bits are intentionally dropped; set count is informational.
  assign unused_ok = ^{AddrM[1:0], (NUM_SET > 0)};

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Scoreboard bench for cache_miss_ctrl: a 16-bit-counter instance plus a
// 2-bit-counter instance sharing the same stimulus for saturation.
module tb_cache_miss_ctrl;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM, CacheHit, mem_ack;
  logic [31:0] AddrM, WriteDataM, CacheData, mem_rdata;
  logic        StallM, FillEn, mem_req, mem_we;
  logic [31:0] ReadDataM, FillAddr, FillData, mem_addr, mem_wdata;
  logic [15:0] AccessCount, MissCount;
  logic        s_StallM, s_FillEn, s_mem_req, s_mem_we;
  logic [31:0] s_ReadDataM, s_FillAddr, s_FillData, s_mem_addr, s_mem_wdata;
  logic [1:0]  s_AccessCount, s_MissCount;

  cache_miss_ctrl #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .AddrM(AddrM),
    .WriteDataM(WriteDataM), .CacheHit(CacheHit), .CacheData(CacheData), .StallM(StallM),
    .ReadDataM(ReadDataM), .FillEn(FillEn), .FillAddr(FillAddr), .FillData(FillData),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .AccessCount(AccessCount), .MissCount(MissCount)
  );

  cache_miss_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .AddrM(AddrM),
    .WriteDataM(WriteDataM), .CacheHit(CacheHit), .CacheData(CacheData), .StallM(s_StallM),
    .ReadDataM(s_ReadDataM), .FillEn(s_FillEn), .FillAddr(s_FillAddr), .FillData(s_FillData),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .AccessCount(s_AccessCount), .MissCount(s_MissCount)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_access, exp_miss;
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  logic [63:0] exp_fill, obs_fill;

  int          obs_stalls, obs_bursts, obs_fills;
  logic        obs_unstable, obs_timeout, obs_req_we;
  logic [31:0] obs_req_addr, obs_req_wdata, obs_rdm_first, obs_rdm_fill;

  // Drives one M-stage memory instruction and acts as the memory: ack is
  // returned ack_k cycles after the instruction is first presented.
  task automatic do_access(input logic rd, input logic wr, input logic hit,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] cdata, input logic [31:0] rdata,
                           input int ack_k);
    logic prev_req;
    logic done;
    prev_req = 1'b0; done = 1'b0;
    obs_stalls = 0; obs_bursts = 0; obs_fills = 0;
    obs_unstable = 1'b0; obs_timeout = 1'b0; obs_req_we = 1'b0;
    obs_req_addr = 32'h0; obs_req_wdata = 32'h0; obs_rdm_fill = 32'h0;
    @(negedge clk);
    MemReadM = rd; MemWriteM = wr; CacheHit = hit; AddrM = addr;
    WriteDataM = wdata; CacheData = cdata;
    for (int c = 0; c < 50; c++) begin
      if (c > 0) @(negedge clk);
      mem_ack   = (mem_req === 1'b1) && (c == ack_k);
      mem_rdata = rdata;
      #1;
      if (c == 0) obs_rdm_first = ReadDataM;
      if (StallM === 1'b1) obs_stalls++;
      if (mem_req === 1'b1 && !prev_req) begin
        obs_bursts++;
        obs_req_addr = mem_addr; obs_req_wdata = mem_wdata; obs_req_we = mem_we;
      end else if (mem_req === 1'b1 && (mem_addr !== obs_req_addr ||
                   mem_wdata !== obs_req_wdata || mem_we !== obs_req_we)) begin
        obs_unstable = 1'b1;
      end
      prev_req = (mem_req === 1'b1);
      if (FillEn === 1'b1) begin
        obs_fills++;
        obs_q.push_back({FillAddr, FillData});
        obs_rdm_fill = ReadDataM;
      end
      if (StallM === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) obs_timeout = 1'b1;
    @(negedge clk);
    MemReadM = 1'b0; MemWriteM = 1'b0; CacheHit = 1'b0; mem_ack = 1'b0;
    #1;
    if (FillEn === 1'b1) obs_fills++;
    if (mem_req === 1'b1 && !prev_req) obs_bursts++;
  endtask

  task automatic test_reset();
    rst = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; CacheHit = 1'b0; mem_ack = 1'b0;
    AddrM = 32'h0; WriteDataM = 32'h0; CacheData = 32'h5555_AAAA; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if ({mem_req, mem_we} !== 2'b00) $display("FAIL reset_req actual=%b required=00", {mem_req, mem_we}); else n_pass++;
    n_checks++; if ({mem_addr, mem_wdata} !== 64'h0) $display("FAIL reset_mem_bus actual=%h required=0", {mem_addr, mem_wdata}); else n_pass++;
    n_checks++; if ({FillEn, StallM} !== 2'b00) $display("FAIL reset_fill_stall actual=%b required=00", {FillEn, StallM}); else n_pass++;
    n_checks++; if ({AccessCount, MissCount} !== 32'h0) $display("FAIL reset_counters actual=%h required=0", {AccessCount, MissCount}); else n_pass++;
    n_checks++; if (ReadDataM !== 32'h5555_AAAA) $display("FAIL reset_readdata actual=%h required=5555aaaa", ReadDataM); else n_pass++;
    exp_access = 16'd0; exp_miss = 16'd0;
  endtask

  task automatic test_load_hit();
    do_access(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 32'h0, 1);
    exp_access++;
    n_checks++; if (obs_stalls !== 0) $display("FAIL hit_stall actual=%0d required=0", obs_stalls); else n_pass++;
    n_checks++; if (obs_rdm_first !== 32'hDEAD_BEEF) $display("FAIL hit_readdata actual=%h required=deadbeef", obs_rdm_first); else n_pass++;
    n_checks++; if (obs_bursts !== 0 || obs_fills !== 0) $display("FAIL hit_no_mem actual=%0d/%0d required=0/0", obs_bursts, obs_fills); else n_pass++;
    n_checks++; if (AccessCount !== exp_access) $display("FAIL hit_access actual=%0d required=%0d", AccessCount, exp_access); else n_pass++;
  endtask

  task automatic test_load_miss(input logic [31:0] addr, input int ack_k, input logic [31:0] rdata);
    exp_q.push_back({addr & 32'hFFFF_FFFC, rdata});
    do_access(1'b1, 1'b0, 1'b0, addr, 32'h0, 32'h0BAD_0BAD, rdata, ack_k);
    exp_access++; exp_miss++;
    n_checks++; if (obs_timeout !== 1'b0) $display("FAIL miss_timeout actual=%b required=0", obs_timeout); else n_pass++;
    n_checks++; if (obs_stalls !== ack_k + 1) $display("FAIL miss_stall_cycles actual=%0d required=%0d", obs_stalls, ack_k + 1); else n_pass++;
    n_checks++; if (obs_bursts !== 1 || obs_unstable !== 1'b0) $display("FAIL miss_req_burst actual=%0d/%b required=1/0", obs_bursts, obs_unstable); else n_pass++;
    n_checks++; if ({obs_req_we, obs_req_addr} !== {1'b0, addr & 32'hFFFF_FFFC}) $display("FAIL miss_mem_addr actual=%b/%h required=0/%h", obs_req_we, obs_req_addr, addr & 32'hFFFF_FFFC); else n_pass++;
    n_checks++; if (obs_fills !== 1 || obs_q.size() != 1) $display("FAIL miss_fill_count actual=%0d required=1", obs_fills); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      exp_fill = exp_q.pop_front(); obs_fill = obs_q.pop_front();
      n_checks++; if (obs_fill !== exp_fill) $display("FAIL miss_fill_word actual=%h required=%h", obs_fill, exp_fill); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
    n_checks++; if (obs_rdm_fill !== rdata) $display("FAIL miss_readdata actual=%h required=%h", obs_rdm_fill, rdata); else n_pass++;
    n_checks++; if ({AccessCount, MissCount} !== {exp_access, exp_miss}) $display("FAIL miss_counters actual=%0d/%0d required=%0d/%0d", AccessCount, MissCount, exp_access, exp_miss); else n_pass++;
  endtask

  task automatic test_store(input logic rd);
    do_access(rd, 1'b1, 1'b0, 32'h0000_0020, 32'hA5A5_A5A5, 32'h0, 32'hFFFF_FFFF, 2);
    exp_access++;
    n_checks++; if (obs_stalls !== 3 || obs_timeout !== 1'b0) $display("FAIL store_stall_cycles actual=%0d required=3", obs_stalls); else n_pass++;
    n_checks++; if (obs_bursts !== 1 || obs_unstable !== 1'b0) $display("FAIL store_req_burst actual=%0d/%b required=1/0", obs_bursts, obs_unstable); else n_pass++;
    n_checks++; if ({obs_req_we, obs_req_addr, obs_req_wdata} !== {1'b1, 32'h0000_0020, 32'hA5A5_A5A5})
      $display("FAIL store_mem_bus actual=%b/%h/%h required=1/00000020/a5a5a5a5", obs_req_we, obs_req_addr, obs_req_wdata); else n_pass++;
    n_checks++; if (obs_fills !== 0) $display("FAIL store_no_fill actual=%0d required=0", obs_fills); else n_pass++;
    n_checks++; if ({AccessCount, MissCount} !== {exp_access, exp_miss}) $display("FAIL store_counters actual=%0d/%0d required=%0d/%0d", AccessCount, MissCount, exp_access, exp_miss); else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_reset_abort();
    logic fill_seen;
    fill_seen = 1'b0;
    @(negedge clk);
    MemReadM = 1'b1; CacheHit = 1'b0; AddrM = 32'h0000_0300;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL abort_req_async actual=%b required=0", mem_req); else n_pass++;
    MemReadM = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      #1; if (FillEn === 1'b1) fill_seen = 1'b1;
      @(negedge clk); mem_ack = 1'b0;
    end
    #1;
    n_checks++; if (u_dut.state_q !== IDLE) $display("FAIL abort_state actual=%0d required=%0d", u_dut.state_q, IDLE); else n_pass++;
    n_checks++; if ({mem_req, StallM, fill_seen} !== 3'b000) $display("FAIL abort_quiet actual=%b required=000", {mem_req, StallM, fill_seen}); else n_pass++;
    n_checks++; if ({AccessCount, MissCount, s_AccessCount, s_MissCount} !== 36'h0)
      $display("FAIL abort_counters actual=%0d/%0d/%0d/%0d required=0", AccessCount, MissCount, s_AccessCount, s_MissCount); else n_pass++;
    exp_access = 16'd0; exp_miss = 16'd0;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      do_access(1'b1, 1'b0, 1'b0, 32'h0000_1000 + 32'(i * 4), 32'h0, 32'h0, 32'h1111_0000 + 32'(i), 1);
      exp_access++; exp_miss++;
    end
    obs_q.delete();
    n_checks++; if (s_MissCount !== 2'd3) $display("FAIL sat_miss actual=%0d required=3", s_MissCount); else n_pass++;
    n_checks++; if (s_AccessCount !== 2'd3) $display("FAIL sat_access actual=%0d required=3", s_AccessCount); else n_pass++;
    n_checks++; if (MissCount !== exp_miss) $display("FAIL wide_miss actual=%0d required=%0d", MissCount, exp_miss); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load_hit();
    test_load_miss(32'h0000_0107, 3, 32'h1234_5678);
    test_load_miss(32'hFFFF_FFFE, 1, 32'h8000_0001);
    test_store(1'b0);
    test_store(1'b1);
    test_reset_abort();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
